dc_trigger_decoder: RTL and testbench

Receiver for the duty-cycle trigger encoding used by the clock-and-trigger combiners. Each period of the combined clock carries one trigger bit: short high time (25% nominal) is 1, long high time (75% nominal) is 0. The block oversamples the incoming combined clock on the local `fastclk` and recovers the trigger level once per period. It also measures the period, tracks link lock and counts trigger events. It sits at the far end of the SMA clock/trigger link, ahead of trigger-consuming logic.

---
 rtl/dc_trigger_decoder_pkg.sv | 15 +
 rtl/dc_trigger_decoder_sync.sv | 25 ++
 rtl/dc_trigger_decoder.sv | 162 ++++++++++++++++
 tb/tb_dc_trigger_decoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dc_trigger_decoder_pkg.sv
// Shared types and constants for the duty-cycle trigger decoder.
// Encoding: short high time carries a 1, long high time carries a 0.
package dc_trig_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

    localparam int   TRIG_CNT_W = 16;
    localparam logic TRIG_SHORT = 1'b1;
    localparam logic TRIG_LONG  = 1'b0;

endpackage

// File: rtl/dc_trigger_decoder_sync.sv
// Two-flop synchroniser bringing the combined clock/trigger line
// into the fastclk domain.
module mySync (
    input  logic fastclk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/dc_trigger_decoder.sv
// Recovers one trigger bit per period of the combined clock by
// oversampling its duty cycle; also tracks period, lock and events.
module dc_trigger_decoder
    import dc_trig_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MIN_PERIOD = 4,
    parameter int MAX_PERIOD = 64,
    parameter int LOCK_COUNT = 4
) (
    input  logic                  fastclk,
    input  logic                  reset,
    input  logic                  enc_clk_in,
    output logic                  trig_out,
    output logic                  trig_valid,
    output logic                  locked,
    output logic                  period_err,
    output logic [CNT_W-1:0]      meas_period,
    output logic [TRIG_CNT_W-1:0] trig_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W:0]   MIN_P    = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]   MAX_P    = (CNT_W+1)'(MAX_PERIOD);
    localparam logic [CNT_W:0]   TMO_P    = (CNT_W+1)'(MAX_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);

    dec_state_t state, state_d;

    logic             s2, s3, rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [CNT_W:0]   p_ext, h_ext, h2;
    logic             valid_per, dec_bit, timeout;
    logic [RUN_W-1:0] run_cnt, run_d, run_inc;
    logic             valid_d, err_d, trig_d;
    logic [CNT_W-1:0] meas_d;

    mySync u_sync (
        .fastclk (fastclk),
        .reset   (reset),
        .d       (enc_clk_in),
        .q       (s2)
    );

    assign rise    = s2 & ~s3;
    assign p_ext   = {1'b0, per_cnt};
    assign h_ext   = {1'b0, hi_cnt};
    assign h2      = {hi_cnt, 1'b0};
    assign run_inc = run_cnt + RUN_W'(1);

    assign valid_per = (p_ext >= MIN_P) && (p_ext <= MAX_P) &&
                       (hi_cnt != '0) && (h_ext < p_ext) &&
                       (h2 != p_ext);
    assign dec_bit   = (h2 < p_ext) ? TRIG_SHORT : TRIG_LONG;
    assign timeout   = (state != SEARCH) && !rise && (p_ext == TMO_P);

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            s3      <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            s3 <= s2;
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (per_cnt != CNT_MAX)
                    per_cnt <= per_cnt + CNT_W'(1);
                if (s2 && hi_cnt != CNT_MAX)
                    hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset)
            state <= SEARCH;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            SEARCH: begin
                if (rise)
                    state_d = TRACK;
            end
            TRACK: begin
                if (rise && valid_per && run_inc == RUN_LOCK)
                    state_d = LOCKED;
                else if (timeout)
                    state_d = SEARCH;
            end
            LOCKED: begin
                if (rise && !valid_per)
                    state_d = TRACK;
                else if (timeout)
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    // Next values of the registered outputs and the lock-run counter.
    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        run_d   = run_cnt;
        trig_d  = trig_out;
        meas_d  = meas_period;
        unique case (state)
            SEARCH: begin
                if (rise)
                    run_d = '0;
            end
            TRACK, LOCKED: begin
                if (rise) begin
                    if (valid_per) begin
                        valid_d = 1'b1;
                        trig_d  = dec_bit;
                        meas_d  = per_cnt;
                        if (run_cnt != RUN_LOCK)
                            run_d = run_inc;
                    end else begin
                        err_d = 1'b1;
                        run_d = '0;
                    end
                end else if (timeout) begin
                    err_d = 1'b1;
                    run_d = '0;
                end
            end
            default: run_d = '0;
        endcase
    end

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            run_cnt     <= '0;
            trig_valid  <= 1'b0;
            period_err  <= 1'b0;
            trig_out    <= 1'b0;
            meas_period <= '0;
            trig_count  <= '0;
        end else begin
            run_cnt     <= run_d;
            trig_valid  <= valid_d;
            period_err  <= err_d;
            trig_out    <= trig_d;
            meas_period <= meas_d;
            trig_count  <= trig_count +
                           TRIG_CNT_W'(trig_d & ~trig_out);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_dc_trigger_decoder.sv
// Directed bench: table of duty-cycle patterns with expected decode
// results, plus reset and timeout sequences.
module tb_dc_trigger_decoder;

    localparam int LOCK_COUNT = 4;

    logic        fastclk = 1'b0;
    logic        reset;
    logic        enc_clk_in;
    logic        trig_out;
    logic        trig_valid;
    logic        locked;
    logic        period_err;
    logic [7:0]  meas_period;
    logic [15:0] trig_count;

    dc_trigger_decoder dut (
        .fastclk     (fastclk),
        .reset       (reset),
        .enc_clk_in  (enc_clk_in),
        .trig_out    (trig_out),
        .trig_valid  (trig_valid),
        .locked      (locked),
        .period_err  (period_err),
        .meas_period (meas_period),
        .trig_count  (trig_count)
    );

    always #5 fastclk = ~fastclk;

    typedef struct {
        logic [7:0]  pat;
        int          len;
        int          reps;
        int          tail;
        int          ev;
        int          ee;
        logic        el;
        logic        et;
        logic [7:0]  em;
        logic [15:0] ec;
        int          eg;
    } vec_t;

    vec_t tbl [11];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int nv, ne, vidx, gap_bad, last_v, cur_gap;
    int glob_last_v = 0;
    int last_e = 0;
    int ovl = 0;
    logic lk_pre, lk_at;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One fastclk cycle: sample outputs at the falling edge, then drive.
    task automatic step(input logic b);
        @(negedge fastclk);
        if (trig_valid) begin
            nv++;
            vidx++;
            if (last_v >= 0 && cur_gap != 0 && cyc - last_v != cur_gap)
                gap_bad++;
            last_v = cyc;
            glob_last_v = cyc;
            if (vidx == LOCK_COUNT - 1) lk_pre = locked;
            if (vidx == LOCK_COUNT) lk_at = locked;
        end
        if (period_err) begin
            ne++;
            last_e = cyc;
        end
        if (trig_valid && period_err) ovl++;
        enc_clk_in = b;
        cyc++;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        nv = 0; ne = 0; vidx = 0; gap_bad = 0; last_v = -1;
        cur_gap = v.eg;
        lk_pre = 1'bx; lk_at = 1'bx;
        for (int r = 0; r < v.reps; r++)
            for (int b = 0; b < v.len; b++)
                step(v.pat[v.len-1-b]);
        for (int t = 0; t < v.tail; t++)
            step(1'b0);
        chk($sformatf("v%0d valid_cnt", i), nv, v.ev);
        chk($sformatf("v%0d err_cnt", i), ne, v.ee);
        chk($sformatf("v%0d locked", i), int'(locked), int'(v.el));
        chk($sformatf("v%0d trig_out", i), int'(trig_out), int'(v.et));
        chk($sformatf("v%0d meas_period", i), int'(meas_period), int'(v.em));
        chk($sformatf("v%0d trig_count", i), int'(trig_count), int'(v.ec));
        if (v.eg != 0)
            chk($sformatf("v%0d gap_bad", i), gap_bad, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " trig_out"}, int'(trig_out), 0);
        chk({tag, " trig_valid"}, int'(trig_valid), 0);
        chk({tag, " locked"}, int'(locked), 0);
        chk({tag, " period_err"}, int'(period_err), 0);
        chk({tag, " meas_period"}, int'(meas_period), 0);
        chk({tag, " trig_count"}, int'(trig_count), 0);
    endtask

    initial begin
        //            pat           len rep tl  ev ee lk  tr    meas   cnt  gap
        tbl[0]  = '{8'b1110,      4, 8, 0, 7, 0, 1'b1, 1'b0, 8'd4, 16'd0, 4};
        tbl[1]  = '{8'b1000,      4, 4, 0, 4, 0, 1'b1, 1'b1, 8'd4, 16'd1, 4};
        tbl[2]  = '{8'b11111100,  8, 3, 0, 3, 0, 1'b1, 1'b0, 8'd8, 16'd1, 8};
        tbl[3]  = '{8'b11000000,  8, 3, 0, 3, 0, 1'b1, 1'b1, 8'd8, 16'd2, 8};
        tbl[4]  = '{8'b10,        2, 6, 4, 1, 5, 1'b0, 1'b1, 8'd8, 16'd2, 0};
        tbl[5]  = '{8'b11110000,  8, 3, 0, 1, 2, 1'b0, 1'b1, 8'd6, 16'd2, 0};
        tbl[6]  = '{8'b1110,      4, 6, 0, 5, 1, 1'b1, 1'b0, 8'd4, 16'd2, 4};
        tbl[7]  = '{8'b1,         1, 150, 0, 1, 1, 1'b0, 1'b0, 8'd4, 16'd2, 0};
        tbl[8]  = '{8'b1000,      4, 7, 0, 5, 0, 1'b1, 1'b1, 8'd4, 16'd3, 4};
        tbl[9]  = '{8'b1000,      4, 4, 0, 3, 0, 1'b0, 1'b1, 8'd4, 16'd1, 4};
        tbl[10] = '{8'b1000,      4, 1, 0, 1, 0, 1'b1, 1'b1, 8'd4, 16'd1, 0};

        reset = 1'b1;
        enc_clk_in = 1'b0;
        repeat (3) @(negedge fastclk);
        chk_zero("por");
        reset = 1'b0;
        repeat (6) step(1'b0);

        for (int i = 0; i < 11; i++) begin
            if (i == 9) begin
                @(posedge fastclk);
                #2;
                reset = 1'b1;
                enc_clk_in = 1'b0;
                #1;
                chk_zero("midrst");
                repeat (3) @(negedge fastclk);
                reset = 1'b0;
            end
            run_vec(i);
            if (i == 0) begin
                chk("lock_before_4th", int'(lk_pre), 0);
                chk("lock_at_4th", int'(lk_at), 1);
            end
            if (i == 7)
                chk("timeout_delay", last_e - glob_last_v, 65);
        end

        chk("valid_err_overlap", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
